serial_subtractor: RTL

//  Bit-serial unsigned subtractor: computes diff = a - b, LSB first, one bit per clock.

---
 rtl/serial_subtractor.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b computed LSB first, one bit per clock,
// behind a start/busy/done handshake. Each slice is two cascaded half-subtractors.

module serial_subtractor_hs (
    input  logic x_i,
    input  logic y_i,
    output logic d_o,
    output logic bo_o
);
    assign d_o  = x_i ^ y_i;
    assign bo_o = ~x_i & y_i;
endmodule

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bf_q, bf_d, borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d1, b1, d_bit, b2, bo_bit;
    logic [WIDTH-1:0] res_nx;

    serial_subtractor_hs u_hs0 (.x_i(ra_q[0]), .y_i(rb_q[0]), .d_o(d1),    .bo_o(b1));
    serial_subtractor_hs u_hs1 (.x_i(d1),      .y_i(bf_q),    .d_o(d_bit), .bo_o(b2));
    assign bo_bit = b1 | b2;

    // The result register only needs the WIDTH-1 bits already produced; the
    // final bit is merged straight into diff on the last shift edge.
    generate
        if (WIDTH == 1) begin : g_w1
            assign res_nx = d_bit;
        end else begin : g_wn
            logic [WIDTH-2:0] res_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                           res_q <= '0;
                else if (state_q == IDLE && start) res_q <= '0;
                else if (state_q == SHIFT)         res_q <= res_nx[WIDTH-1:1];
            end
            assign res_nx = {d_bit, res_q};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            bf_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            bf_q     <= bf_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        bf_d     = bf_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    bf_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                bf_d  = bo_bit;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    diff_d   = res_nx;
                    borrow_d = bo_bit;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
endmodule
